// File: rtl/saida_bcd_seq.sv
// saida_bcd_seq: strobed binary-to-BCD display stage (shift-add-3, one bit per cycle)
// driving active-low seven-segment digits with blanking, sign digit and overflow dash.
module saida_bcd_seq #(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 3,
    parameter int SIGNED   = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clock,
    input  logic                  res,
    input  logic                  out,
    input  logic [DATA_W-1:0]     numero,
    output logic [7*DIGITS-1:0]   segs,
    output logic [6:0]            neg_seg,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]          r_state;
    logic [DATA_W-1:0]   r_mag;
    logic [BW-1:0]       r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;
    logic                r_acc;
    logic                r_pend;
    logic [DATA_W-1:0]   r_pend_word;
    logic [7*DIGITS-1:0] r_segs;
    logic [6:0]          r_neg_seg;
    logic                r_valid;
    logic                r_ovf;

    logic [DATA_W-1:0]   w_src;
    logic                w_src_neg;
    logic [DATA_W-1:0]   w_src_mag;
    logic                w_load;
    logic [BW-1:0]       w_adj;
    logic [7*DIGITS-1:0] w_seg_next;
    logic                w_zrun;
    logic [3:0]          w_nib;

    function automatic logic [6:0] f_dec(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // A new conversion starts either from a fresh strobe or from the pending word.
    assign w_src     = (r_state == S_IDLE) ? numero : r_pend_word;
    assign w_src_neg = (SIGNED != 0) && w_src[DATA_W-1];
    assign w_src_mag = w_src_neg ? -w_src : w_src;
    assign w_load    = ((r_state == S_IDLE) && out) ||
                       ((r_state == S_LATCH) && r_pend);

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_seg_next = '1;
        w_zrun     = 1'b1;
        w_nib      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nib  = r_bcd[4*i +: 4];
            w_zrun = w_zrun && (w_nib == 4'd0);
            if (r_acc)
                w_seg_next[7*i +: 7] = 7'b0111111;
            else if ((BLANK_LZ != 0) && (i != 0) && w_zrun)
                w_seg_next[7*i +: 7] = 7'b1111111;
            else
                w_seg_next[7*i +: 7] = f_dec(w_nib);
        end
    end

    always_ff @(negedge clock) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_acc       <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_word <= '0;
            r_segs      <= '1;
            r_neg_seg   <= 7'b1111111;
            r_valid     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Strobes while busy overwrite the single pending slot.
            if (out && (r_state != S_IDLE)) begin
                r_pend      <= 1'b1;
                r_pend_word <= numero;
            end else if (r_state == S_LATCH) begin
                r_pend <= 1'b0;
            end

            if (w_load) begin
                r_mag <= w_src_mag;
                r_neg <= w_src_neg;
                r_bcd <= '0;
                r_acc <= 1'b0;
                r_cnt <= CW'(DATA_W);
            end

            case (r_state)
                S_IDLE: begin
                    if (out)
                        r_state <= S_CONV;
                end
                S_CONV: begin
                    r_bcd <= {w_adj[BW-2:0], r_mag[DATA_W-1]};
                    r_mag <= {r_mag[DATA_W-2:0], 1'b0};
                    r_acc <= r_acc | w_adj[BW-1];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_segs    <= w_seg_next;
                    r_neg_seg <= r_neg ? 7'b0111111 : 7'b1111111;
                    r_ovf     <= r_acc;
                    r_valid   <= 1'b1;
                    r_state   <= r_pend ? S_CONV : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign segs     = r_segs;
    assign neg_seg  = r_neg_seg;
    assign busy     = (r_state != S_IDLE);
    assign valid    = r_valid;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_saida_bcd_seq.sv
// tb_saida_bcd_seq: three configurations of saida_bcd_seq checked against a
// decimal-arithmetic display model with fixed and random values.
module tb_saida_bcd_seq;

    logic        clk;
    logic        res;
    logic        out_a, out_b, out_c;
    logic [31:0] num_a, num_b, num_c;
    logic [20:0] segs_a, segs_b;
    logic [69:0] segs_c;
    logic [6:0]  neg_a, neg_b, neg_c;
    logic        busy_a, busy_b, busy_c;
    logic        valid_a, valid_b, valid_c;
    logic        ovf_a, ovf_b, ovf_c;

    int total = 0;
    int bad   = 0;

    // a: unsigned, 3 digits, blanking; b: unsigned, 3 digits, no blanking;
    // c: signed, 10 digits, blanking
    saida_bcd_seq #(.DATA_W(32), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)) u_a (
        .clock(clk), .res(res), .out(out_a), .numero(num_a), .segs(segs_a),
        .neg_seg(neg_a), .busy(busy_a), .valid(valid_a), .overflow(ovf_a));
    saida_bcd_seq #(.DATA_W(32), .DIGITS(3), .SIGNED(0), .BLANK_LZ(0)) u_b (
        .clock(clk), .res(res), .out(out_b), .numero(num_b), .segs(segs_b),
        .neg_seg(neg_b), .busy(busy_b), .valid(valid_b), .overflow(ovf_b));
    saida_bcd_seq #(.DATA_W(32), .DIGITS(10), .SIGNED(1), .BLANK_LZ(1)) u_c (
        .clock(clk), .res(res), .out(out_c), .numero(num_c), .segs(segs_c),
        .neg_seg(neg_c), .busy(busy_c), .valid(valid_c), .overflow(ovf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] g_segs(input int w);
        logic [69:0] t;
        t = '1;
        if (w == 0) t[20:0] = segs_a;
        else if (w == 1) t[20:0] = segs_b;
        else t = segs_c;
        return t;
    endfunction

    function automatic logic [6:0] g_neg(input int w);
        return (w == 0) ? neg_a : (w == 1) ? neg_b : neg_c;
    endfunction

    function automatic logic g_busy(input int w);
        return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic g_valid(input int w);
        return (w == 0) ? valid_a : (w == 1) ? valid_b : valid_c;
    endfunction

    function automatic logic g_ovf(input int w);
        return (w == 0) ? ovf_a : (w == 1) ? ovf_b : ovf_c;
    endfunction

    task automatic set_in(input int w, input logic o, input logic [31:0] v);
        case (w)
            0: begin out_a = o; num_a = v; end
            1: begin out_b = o; num_b = v; end
            default: begin out_c = o; num_c = v; end
        endcase
    endtask

    // Decimal reference: digits by division, blanking above the top nonzero digit.
    function automatic void model(input int w, input logic [31:0] v,
                                  output logic [69:0] es, output logic [6:0] en,
                                  output logic eo);
        int nd;
        bit sg, blz, ng;
        longint unsigned mag, lim, m;
        int dg[10];
        int hi;
        logic [6:0] tbl[10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        nd  = (w == 2) ? 10 : 3;
        sg  = (w == 2);
        blz = (w != 1);
        ng  = sg && v[31];
        mag = ng ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        eo = (mag >= lim);
        m  = mag;
        hi = 0;
        for (int i = 0; i < nd; i++) begin
            dg[i] = int'(m % 10);
            m = m / 10;
            if (dg[i] != 0) hi = i;
        end
        es = '1;
        for (int i = 0; i < nd; i++) begin
            if (eo) es[7*i +: 7] = 7'b0111111;
            else if (!(blz && i > hi)) es[7*i +: 7] = tbl[dg[i]];
        end
        en = ng ? 7'b0111111 : 7'b1111111;
    endfunction

    // One-cycle strobe, then wait (bounded) for valid; lat = edges after capture.
    task automatic run_conv(input int w, input logic [31:0] v, output int lat,
                            output logic [69:0] s, output logic [6:0] n,
                            output logic o);
        @(posedge clk); set_in(w, 1'b1, v);
        @(posedge clk); set_in(w, 1'b0, v);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            if (g_valid(w) === 1'b1) begin
                lat = k;
                break;
            end
        end
        s = g_segs(w);
        n = g_neg(w);
        o = g_ovf(w);
    endtask

    task automatic test_reset;
        res = 1'b1;
        set_in(0, 1'b0, 32'd0);
        set_in(1, 1'b0, 32'd0);
        set_in(2, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        for (int w = 0; w < 3; w++) begin
            total++;
            if (g_segs(w) !== '1) begin
                bad++; $display("FAIL reset_segs[%0d] got=%h exp=all-ones", w, g_segs(w));
            end
            total++;
            if (g_neg(w) !== 7'b1111111) begin
                bad++; $display("FAIL reset_neg[%0d] got=%b exp=1111111", w, g_neg(w));
            end
            total++;
            if ({g_busy(w), g_valid(w), g_ovf(w)} !== 3'b000) begin
                bad++; $display("FAIL reset_flags[%0d] got=%b exp=000", w,
                                {g_busy(w), g_valid(w), g_ovf(w)});
            end
        end
        res = 1'b0;
    endtask

    task automatic test_latency;
        int lat;
        logic [69:0] s, es;
        logic [6:0] n, en;
        logic o, eo;
        run_conv(0, 32'd123, lat, s, n, o);
        model(0, 32'd123, es, en, eo);
        total++;
        if (lat != 33) begin
            bad++; $display("FAIL latency_123 got=%0d exp=33", lat);
        end
        total++;
        if (s !== es || o !== eo || n !== en) begin
            bad++; $display("FAIL disp_123 got=%h/%b/%b exp=%h/%b/%b", s, n, o, es, en, eo);
        end
        @(posedge clk);
        total++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL valid_pulse got v=%b b=%b exp v=0 b=0", valid_a, busy_a);
        end
        // Old display must persist while the next value converts.
        set_in(0, 1'b1, 32'd456);
        @(posedge clk); set_in(0, 1'b0, 32'd456);
        repeat (10) @(posedge clk);
        total++;
        if (busy_a !== 1'b1 || valid_a !== 1'b0 || g_segs(0) !== es) begin
            bad++; $display("FAIL hold_during_conv got b=%b v=%b s=%h exp b=1 v=0 s=%h",
                            busy_a, valid_a, g_segs(0), es);
        end
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            if (valid_a === 1'b1) begin lat = k; break; end
        end
        model(0, 32'd456, es, en, eo);
        total++;
        if (lat < 0 || g_segs(0) !== es) begin
            bad++; $display("FAIL disp_456 got=%h lat=%0d exp=%h", g_segs(0), lat, es);
        end
    endtask

    task automatic test_table;
        int tw[12];
        logic [31:0] tv[12];
        int lat;
        logic [69:0] s, es;
        logic [6:0] n, en;
        logic o, eo;
        tw = '{0, 1, 0, 1, 0, 0, 0, 2, 2, 2, 2, 1};
        tv = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd1000, 32'd999, 32'hFFFFFFFF,
               32'hFFFFFFD6, 32'h80000000, 32'd0, 32'h7FFFFFFF, 32'd1000};
        for (int i = 0; i < 12; i++) begin
            run_conv(tw[i], tv[i], lat, s, n, o);
            model(tw[i], tv[i], es, en, eo);
            total++;
            if (lat != 33 || s !== es || n !== en || o !== eo) begin
                bad++;
                $display("FAIL table[%0d] v=%h got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=33",
                         i, tv[i], s, n, o, lat, es, en, eo);
            end
        end
    endtask

    task automatic test_random;
        int w, lat;
        logic [31:0] v;
        logic [69:0] s, es;
        logic [6:0] n, en;
        logic o, eo;
        for (int i = 0; i < 60; i++) begin
            w = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 20);
                1: v = $urandom_range(990, 1010);
                2: v = $urandom_range(0, 999);
                default: v = $urandom;
            endcase
            run_conv(w, v, lat, s, n, o);
            model(w, v, es, en, eo);
            total++;
            if (lat != 33 || s !== es || n !== en || o !== eo) begin
                bad++;
                $display("FAIL random[%0d] w=%0d v=%h got=%h/%b/%b lat=%0d exp=%h/%b/%b",
                         i, w, v, s, n, o, lat, es, en, eo);
            end
        end
    endtask

    task automatic test_back_to_back;
        int k1, d, extra;
        logic [69:0] es;
        logic [6:0] en;
        logic eo;
        @(posedge clk); set_in(0, 1'b1, 32'd7);
        @(posedge clk); set_in(0, 1'b1, 32'd9);
        @(posedge clk); set_in(0, 1'b0, 32'd9);
        repeat (4) @(posedge clk);
        set_in(0, 1'b1, 32'd8);
        @(posedge clk); set_in(0, 1'b0, 32'd8);
        k1 = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            if (valid_a === 1'b1) begin k1 = k; break; end
        end
        model(0, 32'd7, es, en, eo);
        total++;
        if (k1 < 0 || segs_a !== es[20:0]) begin
            bad++; $display("FAIL b2b_first got=%h exp=%h", segs_a, es[20:0]);
        end
        d = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            if (valid_a === 1'b1) begin d = k; break; end
        end
        model(0, 32'd8, es, en, eo);
        total++;
        if (d != 33 || segs_a !== es[20:0]) begin
            bad++; $display("FAIL b2b_second got=%h gap=%0d exp=%h gap=33", segs_a, d, es[20:0]);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (valid_a === 1'b1) extra++;
        end
        total++;
        if (extra != 0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL b2b_no_third got valids=%0d busy=%b exp 0/0", extra, busy_a);
        end
    endtask

    task automatic test_reset_abort;
        int cnt, lat;
        logic [69:0] s, es;
        logic [6:0] n, en;
        logic o, eo;
        @(posedge clk); set_in(0, 1'b1, 32'd456);
        @(posedge clk); set_in(0, 1'b1, 32'd789);
        @(posedge clk); set_in(0, 1'b0, 32'd789);
        repeat (7) @(posedge clk);
        res = 1'b1;
        @(posedge clk);
        res = 1'b0;
        total++;
        if (segs_a !== '1 || neg_a !== 7'b1111111 || busy_a !== 1'b0 ||
            valid_a !== 1'b0 || ovf_a !== 1'b0) begin
            bad++; $display("FAIL abort_state got s=%h n=%b b=%b v=%b o=%b exp blank/idle",
                            segs_a, neg_a, busy_a, valid_a, ovf_a);
        end
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            if (valid_a === 1'b1 || busy_a === 1'b1) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++; $display("FAIL abort_quiet got active_cycles=%0d exp=0", cnt);
        end
        run_conv(0, 32'd321, lat, s, n, o);
        model(0, 32'd321, es, en, eo);
        total++;
        if (lat != 33 || s !== es || o !== eo) begin
            bad++; $display("FAIL abort_recover got=%h lat=%0d exp=%h lat=33", s, lat, es);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_table;
        test_random;
        test_back_to_back;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
